// File: rtl/ac_vrhot_throttle_filter.sv
// VR-hot / throttle alarm conditioner.
// Each of the three active-low alarm pins goes through a 2-FF synchronizer, a
// debounce/stretch FSM and a sticky status + saturating event counter. The
// filtered outputs are flops, so the downstream PROCHOT/MEMHOT combiner only
// ever sees glitch-free levels.

module ac_vrhot_throttle_chan #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int STRETCH_CYCLES  = 2000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       enable,
    input  logic       pinN,
    input  logic       clrStatus,
    output logic       filtN,
    output logic       status,
    output logic [7:0] eventCnt
);
    localparam int MaxC = (DEBOUNCE_CYCLES > STRETCH_CYCLES) ? DEBOUNCE_CYCLES : STRETCH_CYCLES;
    localparam int CW   = $clog2(MaxC + 1);
    localparam int RW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DebC     = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] StretchC = CW'(STRETCH_CYCLES);
    localparam logic [RW-1:0] DebR     = RW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StIdle, StQual, StAssert, StRel} state_t;

    state_t          state, stateNxt;
    logic [CW-1:0]   cnt, cntNxt;
    logic [RW-1:0]   rcnt, rcntNxt;
    logic            sync1, s;
    logic            filtNxt;
    logic            assertEvent;

    // Two-flop synchronizer; idles high so reset looks like a deasserted pin.
    // It keeps running while disabled so a re-enable sees the current level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= pinN;
            s     <= sync1;
        end
    end

    // State register, counters and the registered filtered output.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= StIdle;
            cnt   <= '0;
            rcnt  <= '0;
            filtN <= 1'b1;
        end else begin
            state <= stateNxt;
            cnt   <= cntNxt;
            rcnt  <= rcntNxt;
            filtN <= filtNxt;
        end
    end

    // Next-state: qualify assertion, hold the minimum width, qualify release.
    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        rcntNxt  = rcnt;
        if (!enable) begin
            stateNxt = StIdle;
            cntNxt   = '0;
            rcntNxt  = '0;
        end else begin
            case (state)
                StIdle: begin
                    if (!s) begin
                        stateNxt = StQual;
                        cntNxt   = CW'(1);
                    end
                end
                StQual: begin
                    if (s) begin
                        stateNxt = StIdle;
                        cntNxt   = '0;
                    end else if (cnt == DebC) begin
                        stateNxt = StAssert;
                        cntNxt   = CW'(1);
                    end else begin
                        cntNxt = cnt + 1'b1;
                    end
                end
                StAssert: begin
                    // cnt is the age since ASSERT entry, saturating at the stretch width
                    if (cnt < StretchC) cntNxt = cnt + 1'b1;
                    if (s && (cnt >= StretchC)) begin
                        stateNxt = StRel;
                        rcntNxt  = RW'(1);
                    end
                end
                StRel: begin
                    // a low sample here is a glitch: fall back to ASSERT keeping cnt
                    if (!s) begin
                        stateNxt = StAssert;
                    end else if (rcnt == DebR) begin
                        stateNxt = StIdle;
                        cntNxt   = '0;
                        rcntNxt  = '0;
                    end else begin
                        rcntNxt = rcnt + 1'b1;
                    end
                end
                default: begin
                    stateNxt = StIdle;
                    cntNxt   = '0;
                    rcntNxt  = '0;
                end
            endcase
        end
    end

    // Outputs: level from the next state (so it is a plain flop), event on QUAL->ASSERT.
    always_comb begin
        filtNxt     = !((stateNxt == StAssert) || (stateNxt == StRel));
        assertEvent = (state == StQual) && (stateNxt == StAssert);
    end

    // Sticky status and saturating counter; an event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            status   <= 1'b0;
            eventCnt <= '0;
        end else if (assertEvent) begin
            status <= 1'b1;
            if (clrStatus)             eventCnt <= 8'd1;
            else if (eventCnt != 8'hFF) eventCnt <= eventCnt + 8'd1;
        end else if (clrStatus) begin
            status   <= 1'b0;
            eventCnt <= '0;
        end
    end
endmodule

module ac_vrhot_throttle_filter #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int STRETCH_CYCLES  = 2000
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEnable,
    input  logic        iIRQ_CPU_VRHOT_N,
    input  logic        iIRQ_MEM_VRHOT_N,
    input  logic        iFM_SYS_THROTTLE_N,
    input  logic        iClrStatus,
    output logic        oIRQ_CPU_VRHOT_LVC3_N,
    output logic        oIRQ_CPU_MEM_VRHOT_N,
    output logic        oFM_SYS_THROTTLE_LVC3_N,
    output logic [2:0]  oStatus,
    output logic [23:0] oEventCnt
);
    localparam int NumCh = 3;

    logic [NumCh-1:0]      pinN;
    logic [NumCh-1:0]      filtN;
    logic [NumCh-1:0]      status;
    logic [NumCh-1:0][7:0] eventCnt;

    assign pinN = {iFM_SYS_THROTTLE_N, iIRQ_MEM_VRHOT_N, iIRQ_CPU_VRHOT_N};

    genvar ch;
    generate
        for (ch = 0; ch < NumCh; ch++) begin : gCh
            ac_vrhot_throttle_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .STRETCH_CYCLES (STRETCH_CYCLES)
            ) uChan (
                .clk      (iClk),
                .rstN     (iRst_n),
                .enable   (iEnable),
                .pinN     (pinN[ch]),
                .clrStatus(iClrStatus),
                .filtN    (filtN[ch]),
                .status   (status[ch]),
                .eventCnt (eventCnt[ch])
            );
        end
    endgenerate

    assign oIRQ_CPU_VRHOT_LVC3_N   = filtN[0];
    assign oIRQ_CPU_MEM_VRHOT_N    = filtN[1];
    assign oFM_SYS_THROTTLE_LVC3_N = filtN[2];
    assign oStatus                 = status;
    assign oEventCnt               = eventCnt;
endmodule
